// File: rtl/divider_arbiter_if.sv
// Requester-side bus of divider_arbiter: request operands/handshake and routed responses.
// master = requester clients, slave = arbiter.
interface divider_arbiter_if #(
    parameter int unsigned N   = 5,
    parameter int unsigned M   = 3,
    parameter int unsigned REQ = 4,
    parameter int unsigned IDW = 2
);
    logic [REQ-1:0]   req_valid;
    logic [REQ-1:0]   req_ready;
    logic [REQ*N-1:0] req_dividend;
    logic [REQ*M-1:0] req_divisor;
    logic [REQ-1:0]   rsp_valid;
    logic [IDW-1:0]   rsp_id;
    logic [N-1:0]     rsp_merchant;
    logic [N-1:0]     rsp_remainder;

    modport master (
        output req_valid, req_dividend, req_divisor,
        input  req_ready, rsp_valid, rsp_id, rsp_merchant, rsp_remainder
    );

    modport slave (
        input  req_valid, req_dividend, req_divisor,
        output req_ready, rsp_valid, rsp_id, rsp_merchant, rsp_remainder
    );
endinterface

// File: rtl/divider_arbiter.sv
// Round-robin arbiter sharing one fixed-latency pipelined divider among REQ requesters.
// Optional DIVZERO_BYPASS_EN: zero-divisor requests skip the divider and return all-ones/dividend.
module divider_arbiter #(
    parameter int unsigned N   = 5,
    parameter int unsigned M   = 3,
    parameter int unsigned REQ = 4,
    parameter int unsigned LAT = 5,
    parameter int unsigned IDW = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  pause,
    divider_arbiter_if.slave      cli,
    output logic                  div_rst_n,
    output logic                  div_data_rdy,
    output logic [N-1:0]          div_dividend,
    output logic [M-1:0]          div_divisor,
    input  logic                  div_rdy,
    input  logic [N-1:0]          div_merchant,
    input  logic [N-1:0]          div_remainder,
    output logic                  idle,
    output logic                  err_sync
);

    localparam int unsigned CNT_MAX = LAT + 2;
    localparam int unsigned CNTW    = $clog2(CNT_MAX + 1);
    localparam int unsigned PW      = IDW + 1;

    // Arbitration state and grant
    logic [IDW-1:0]  rr_ptr;
    logic [PW-1:0]   cand;
    logic            grant_any;
    logic [IDW-1:0]  grant_idx;
    logic [REQ-1:0]  grant_vec;
    logic [N-1:0]    grant_dividend;
    logic [M-1:0]    grant_divisor;
    logic            issue;

    // Tag pipeline, stage 0 aligned with div_data_rdy, stage LAT with div_rdy
    logic [LAT:0]    tag_valid;
    logic [IDW-1:0]  tag_id [LAT+1];
`ifdef DIVZERO_BYPASS_EN
    logic [LAT:0]    tag_byp;
    logic [N-1:0]    tag_dvd [LAT+1];
    logic            byp;
`endif

    // Response path
    logic            exp_rdy;
    logic            rsp_fire;
    logic [N-1:0]    rsp_merchant_nx;
    logic [N-1:0]    rsp_remainder_nx;
    logic [REQ-1:0]  rsp_valid_q;
    logic [IDW-1:0]  rsp_id_q;
    logic [N-1:0]    rsp_merchant_q;
    logic [N-1:0]    rsp_remainder_q;
    logic [CNTW-1:0] count;

    assign div_rst_n         = ~rst;
    assign cli.req_ready     = grant_vec;
    assign cli.rsp_valid     = rsp_valid_q;
    assign cli.rsp_id        = rsp_id_q;
    assign cli.rsp_merchant  = rsp_merchant_q;
    assign cli.rsp_remainder = rsp_remainder_q;
    assign idle              = rst | ((count == '0) & ~div_data_rdy);

    // Round-robin search starting at rr_ptr, first valid requester wins
    always_comb begin
        grant_any = 1'b0;
        grant_idx = '0;
        grant_vec = '0;
        cand      = '0;
        if (!rst && !pause) begin
            for (int k = 0; k < REQ; k++) begin
                cand = PW'({1'b0, rr_ptr}) + PW'(k);
                if (cand >= PW'(REQ)) begin
                    cand = cand - PW'(REQ);
                end
                if (!grant_any && cli.req_valid[IDW'(cand)]) begin
                    grant_any = 1'b1;
                    grant_idx = IDW'(cand);
                end
            end
        end
        if (grant_any) begin
            grant_vec[grant_idx] = 1'b1;
        end
    end

    always_comb begin
        grant_dividend = cli.req_dividend[32'(grant_idx) * N +: N];
        grant_divisor  = cli.req_divisor[32'(grant_idx) * M +: M];
`ifdef DIVZERO_BYPASS_EN
        byp   = grant_any & (grant_divisor == '0);
        issue = grant_any & ~byp;
`else
        issue = grant_any;
`endif
    end

    // Stage LAT decides whether a response is produced and what divider activity is expected
    always_comb begin
        exp_rdy          = tag_valid[LAT];
        rsp_fire         = tag_valid[LAT] & div_rdy;
        rsp_merchant_nx  = div_merchant;
        rsp_remainder_nx = div_remainder;
`ifdef DIVZERO_BYPASS_EN
        exp_rdy  = tag_valid[LAT] & ~tag_byp[LAT];
        rsp_fire = (exp_rdy & div_rdy) | (tag_valid[LAT] & tag_byp[LAT]);
        if (tag_byp[LAT]) begin
            rsp_merchant_nx  = '1;
            rsp_remainder_nx = tag_dvd[LAT];
        end
`endif
    end

    // Pointer, issue port and tag pipeline
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr       <= '0;
            div_data_rdy <= 1'b0;
            div_dividend <= '0;
            div_divisor  <= '0;
            tag_valid    <= '0;
            for (int k = 0; k <= LAT; k++) begin
                tag_id[k] <= '0;
            end
`ifdef DIVZERO_BYPASS_EN
            tag_byp <= '0;
            for (int k = 0; k <= LAT; k++) begin
                tag_dvd[k] <= '0;
            end
`endif
        end else begin
            if (grant_any) begin
                rr_ptr <= (grant_idx == IDW'(REQ - 1)) ? '0 : grant_idx + IDW'(1);
            end
            div_data_rdy <= issue;
            if (issue) begin
                div_dividend <= grant_dividend;
                div_divisor  <= grant_divisor;
            end
            tag_valid[0] <= grant_any;
            tag_id[0]    <= grant_idx;
            for (int k = 1; k <= LAT; k++) begin
                tag_valid[k] <= tag_valid[k-1];
                tag_id[k]    <= tag_id[k-1];
            end
`ifdef DIVZERO_BYPASS_EN
            tag_byp[0] <= byp;
            tag_dvd[0] <= grant_dividend;
            for (int k = 1; k <= LAT; k++) begin
                tag_byp[k] <= tag_byp[k-1];
                tag_dvd[k] <= tag_dvd[k-1];
            end
`endif
        end
    end

    // Response registers, misalignment flag and outstanding counter
    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_valid_q     <= '0;
            rsp_id_q        <= '0;
            rsp_merchant_q  <= '0;
            rsp_remainder_q <= '0;
            err_sync        <= 1'b0;
            count           <= '0;
        end else begin
            rsp_valid_q <= '0;
            if (rsp_fire) begin
                rsp_valid_q     <= REQ'(1) << tag_id[LAT];
                rsp_id_q        <= tag_id[LAT];
                rsp_merchant_q  <= rsp_merchant_nx;
                rsp_remainder_q <= rsp_remainder_nx;
            end
            if (div_rdy != exp_rdy) begin
                err_sync <= 1'b1;
            end
            // A response is retired the cycle rsp_valid is presented
            if (grant_any && (rsp_valid_q == '0)) begin
                if (count != CNTW'(CNT_MAX)) begin
                    count <= count + CNTW'(1);
                end
            end else if (!grant_any && (rsp_valid_q != '0)) begin
                if (count != '0) begin
                    count <= count - CNTW'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_divider_arbiter.sv
// Directed testbench for divider_arbiter with a behavioural fixed-latency divider model.
module tb_divider_arbiter;

    localparam int unsigned N   = 5;
    localparam int unsigned M   = 3;
    localparam int unsigned REQ = 4;
    localparam int unsigned LAT = 5;
    localparam int unsigned IDW = 2;

    logic           clk = 1'b0;
    logic           rst;
    logic           pause;
    logic           div_rst_n;
    logic           div_data_rdy;
    logic [N-1:0]   div_dividend;
    logic [M-1:0]   div_divisor;
    logic           div_rdy;
    logic [N-1:0]   div_merchant;
    logic [N-1:0]   div_remainder;
    logic           idle;
    logic           err_sync;
    logic           force_rdy;

    always #5 clk = ~clk;

    divider_arbiter_if #(.N(N), .M(M), .REQ(REQ), .IDW(IDW)) bus ();

    divider_arbiter #(.N(N), .M(M), .REQ(REQ), .LAT(LAT), .IDW(IDW)) dut (
        .clk           (clk),
        .rst           (rst),
        .pause         (pause),
        .cli           (bus),
        .div_rst_n     (div_rst_n),
        .div_data_rdy  (div_data_rdy),
        .div_dividend  (div_dividend),
        .div_divisor   (div_divisor),
        .div_rdy       (div_rdy),
        .div_merchant  (div_merchant),
        .div_remainder (div_remainder),
        .idle          (idle),
        .err_sync      (err_sync)
    );

    // Divider model: LAT cycles from sampled data_rdy to rdy; x/0 gives all ones, remainder x
    logic [LAT-1:0] dm_v;
    logic [N-1:0]   dm_q [LAT];
    logic [N-1:0]   dm_r [LAT];

    always @(posedge clk) begin
        if (!div_rst_n) begin
            dm_v <= '0;
        end else begin
            dm_v <= {dm_v[LAT-2:0], div_data_rdy};
            if (div_divisor == '0) begin
                dm_q[0] <= '1;
                dm_r[0] <= div_dividend;
            end else begin
                dm_q[0] <= div_dividend / N'(div_divisor);
                dm_r[0] <= div_dividend % N'(div_divisor);
            end
            for (int k = 1; k < LAT; k++) begin
                dm_q[k] <= dm_q[k-1];
                dm_r[k] <= dm_r[k-1];
            end
        end
    end

    assign div_rdy       = dm_v[LAT-1] | force_rdy;
    assign div_merchant  = dm_q[LAT-1];
    assign div_remainder = dm_r[LAT-1];

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int q_vld[$];
    int q_id[$];
    int q_m[$];
    int q_r[$];
    int q_cyc[$];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Advance to the middle of the next cycle and log any response seen there
    task automatic next();
        @(negedge clk);
        #1;
        cyc++;
        if (bus.rsp_valid != '0) begin
            q_vld.push_back(int'(bus.rsp_valid));
            q_id.push_back(int'(bus.rsp_id));
            q_m.push_back(int'(bus.rsp_merchant));
            q_r.push_back(int'(bus.rsp_remainder));
            q_cyc.push_back(cyc);
        end
    endtask

    task automatic clear_log();
        q_vld.delete();
        q_id.delete();
        q_m.delete();
        q_r.delete();
        q_cyc.delete();
    endtask

    task automatic set_ops(input int idx, input int dvd, input int dvs);
        bus.req_dividend[idx*N +: N] = N'(dvd);
        bus.req_divisor[idx*M +: M]  = M'(dvs);
    endtask

    int t0;
    int exp_id[8];
    int exp_m[4];
    int exp_r[4];
    int b_id[3];
    int b_m[3];
    int b_r[3];
    logic [31:0] byp_slot_rdy;

    initial begin
        rst              = 1'b1;
        pause            = 1'b0;
        force_rdy        = 1'b0;
        bus.req_valid    = '1;
        bus.req_dividend = '0;
        bus.req_divisor  = '0;

        // Reset state
        next();
        #1;
        check_eq("rst_ready", 32'(bus.req_ready), 0);
        check_eq("rst_idle", 32'(idle), 1);
        next();
        check_eq("rst_data_rdy", 32'(div_data_rdy), 0);
        check_eq("rst_rsp_valid", 32'(bus.rsp_valid), 0);
        check_eq("rst_err", 32'(err_sync), 0);
        check_eq("rst_div_rst_n", 32'(div_rst_n), 0);
        rst           = 1'b0;
        bus.req_valid = '0;

        // Single request: req 2 gives 23/4
        next();
        t0 = cyc;
        bus.req_valid = 4'b0100;
        set_ops(2, 23, 4);
        #1;
        check_eq("t1_grant", 32'(bus.req_ready), 32'h4);
        check_eq("t1_div_rst_n", 32'(div_rst_n), 1);
        next();
        bus.req_valid = '0;
        check_eq("t1_issue", 32'(div_data_rdy), 1);
        check_eq("t1_dividend", 32'(div_dividend), 23);
        check_eq("t1_divisor", 32'(div_divisor), 4);
        check_eq("t1_busy", 32'(idle), 0);
        repeat (5) next();
        check_eq("t1_rsp_early", 32'(bus.rsp_valid), 0);
        next();
        check_eq("t1_rsp_cycle", cyc - t0, 7);
        check_eq("t1_rsp_valid", 32'(bus.rsp_valid), 32'h4);
        check_eq("t1_rsp_id", 32'(bus.rsp_id), 2);
        check_eq("t1_merchant", 32'(bus.rsp_merchant), 5);
        check_eq("t1_remainder", 32'(bus.rsp_remainder), 3);
        check_eq("t1_idle_rsp", 32'(idle), 0);
        next();
        check_eq("t1_idle_after", 32'(idle), 1);
        check_eq("t1_rsp_drop", 32'(bus.rsp_valid), 0);

        // Pause while req 1 waits; pointer is at 3
        clear_log();
        next();
        pause         = 1'b1;
        bus.req_valid = 4'b0010;
        set_ops(1, 13, 3);
        #1;
        check_eq("pause_ready0", 32'(bus.req_ready), 0);
        for (int k = 0; k < 2; k++) begin
            next();
            #1;
            check_eq("pause_ready", 32'(bus.req_ready), 0);
        end
        pause = 1'b0;
        #1;
        check_eq("pause_release", 32'(bus.req_ready), 32'h2);
        next();
        bus.req_valid = '0;
        repeat (8) next();
        check_eq("pause_rsp_count", q_vld.size(), 1);
        if (q_vld.size() == 1) begin
            check_eq("pause_rsp_valid", q_vld[0], 2);
            check_eq("pause_rsp_id", q_id[0], 1);
            check_eq("pause_merchant", q_m[0], 4);
            check_eq("pause_remainder", q_r[0], 1);
        end

        // Reset with three requests in flight; pointer is at 2
        clear_log();
        set_ops(0, 20, 3);
        set_ops(2, 9, 2);
        next();
        bus.req_valid = 4'b0111;
        #1;
        check_eq("rr_grant_a", 32'(bus.req_ready), 32'h4);
        next();
        #1;
        check_eq("rr_grant_b", 32'(bus.req_ready), 32'h1);
        next();
        #1;
        check_eq("rr_grant_c", 32'(bus.req_ready), 32'h2);
        next();
        rst = 1'b1;
        #1;
        check_eq("midrst_ready", 32'(bus.req_ready), 0);
        check_eq("midrst_idle", 32'(idle), 1);
        next();
        rst           = 1'b0;
        bus.req_valid = '0;
        check_eq("midrst_data_rdy", 32'(div_data_rdy), 0);
        check_eq("midrst_dividend", 32'(div_dividend), 0);
        check_eq("midrst_divisor", 32'(div_divisor), 0);
        check_eq("midrst_rsp_id", 32'(bus.rsp_id), 0);
        check_eq("midrst_merchant", 32'(bus.rsp_merchant), 0);
        check_eq("midrst_remainder", 32'(bus.rsp_remainder), 0);
        repeat (10) next();
        check_eq("midrst_no_rsp", q_vld.size(), 0);
        check_eq("midrst_err", 32'(err_sync), 0);
        check_eq("midrst_idle_after", 32'(idle), 1);

        // All four requesters valid for 8 cycles; pointer restarts at 0
        clear_log();
        set_ops(0, 20, 3);
        set_ops(1, 31, 7);
        set_ops(2, 9, 2);
        set_ops(3, 7, 5);
        exp_m = '{6, 4, 4, 1};
        exp_r = '{2, 3, 1, 2};
        for (int k = 0; k < 8; k++) begin
            next();
            if (k == 0) t0 = cyc;
            bus.req_valid = 4'b1111;
            exp_id[k] = k % 4;
            #1;
            check_eq("stream_grant", 32'(bus.req_ready), 32'(1) << (k % 4));
        end
        next();
        bus.req_valid = '0;
        repeat (9) next();
        check_eq("stream_rsp_count", q_vld.size(), 8);
        if (q_vld.size() == 8) begin
            for (int k = 0; k < 8; k++) begin
                check_eq("stream_rsp_valid", q_vld[k], 1 << exp_id[k]);
                check_eq("stream_rsp_id", q_id[k], exp_id[k]);
                check_eq("stream_merchant", q_m[k], exp_m[exp_id[k]]);
                check_eq("stream_remainder", q_r[k], exp_r[exp_id[k]]);
                check_eq("stream_latency", q_cyc[k] - t0, 7 + k);
            end
        end
        check_eq("stream_idle", 32'(idle), 1);
        check_eq("stream_err", 32'(err_sync), 0);

        // Spurious div_rdy with no valid tag
        clear_log();
        next();
        force_rdy = 1'b1;
        next();
        force_rdy = 1'b0;
        check_eq("spur_err_set", 32'(err_sync), 1);
        repeat (3) next();
        check_eq("spur_err_sticky", 32'(err_sync), 1);
        check_eq("spur_no_rsp", q_vld.size(), 0);
        rst = 1'b1;
        next();
        rst = 1'b0;
        check_eq("spur_err_clear", 32'(err_sync), 0);

        // Zero divisor between two normal requests: 10/3, 17/0, 14/4
`ifdef DIVZERO_BYPASS_EN
        byp_slot_rdy = 0;
`else
        byp_slot_rdy = 1;
`endif
        clear_log();
        set_ops(0, 10, 3);
        set_ops(3, 17, 0);
        set_ops(1, 14, 4);
        next();
        t0 = cyc;
        bus.req_valid = 4'b0001;
        #1;
        check_eq("dz_grant0", 32'(bus.req_ready), 32'h1);
        next();
        bus.req_valid = 4'b1000;
        check_eq("dz_issue0", 32'(div_data_rdy), 1);
        #1;
        check_eq("dz_grant3", 32'(bus.req_ready), 32'h8);
        next();
        bus.req_valid = 4'b0010;
        check_eq("dz_issue3", 32'(div_data_rdy), byp_slot_rdy);
        #1;
        check_eq("dz_grant1", 32'(bus.req_ready), 32'h2);
        next();
        bus.req_valid = '0;
        check_eq("dz_issue1", 32'(div_data_rdy), 1);
        check_eq("dz_dividend1", 32'(div_dividend), 14);
        repeat (8) next();
        b_id = '{0, 3, 1};
        b_m  = '{3, 31, 3};
        b_r  = '{1, 17, 2};
        check_eq("dz_rsp_count", q_vld.size(), 3);
        if (q_vld.size() == 3) begin
            for (int k = 0; k < 3; k++) begin
                check_eq("dz_rsp_valid", q_vld[k], 1 << b_id[k]);
                check_eq("dz_rsp_id", q_id[k], b_id[k]);
                check_eq("dz_merchant", q_m[k], b_m[k]);
                check_eq("dz_remainder", q_r[k], b_r[k]);
                check_eq("dz_latency", q_cyc[k] - t0, 7 + k);
            end
        end
        check_eq("dz_err", 32'(err_sync), 0);
        check_eq("dz_idle", 32'(idle), 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
